// File: rtl/pipe_alu_pkg.sv
// pipe_alu_pkg: opcode constants and control state shared by the ALU and its bench
package pipe_alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_XOR    = 4'd3;
    localparam logic [3:0] OP_SLL    = 4'd4;
    localparam logic [3:0] OP_SRA    = 4'd5;
    localparam logic [3:0] OP_ROR    = 4'd6;
    localparam logic [3:0] OP_PADDSB = 4'd7;
    localparam logic [3:0] OP_LHB    = 4'd10;
    localparam logic [3:0] OP_LLB    = 4'd11;
    localparam logic [3:0] OP_MUL    = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        MUL_BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one multiplier bit per cycle, low WIDTH bits of the product
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // product is the accumulator after the current step, so it is final on the done cycle
    assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));

    // load operands on start, then add/shift once per cycle until the last bit
    always_comb begin
        busy_d   = busy_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            busy_d   = 1'b1;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
        end else if (busy_q) begin
            acc_d    = product;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            busy_d   = !done;
        end
    end

    // multiplier state register; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_alu.sv
// pipe_alu: registered ALU with single-cycle ops, iterative MUL and valid/ready handshakes
module pipe_alu
    import pipe_alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [WIDTH/2-1:0]       imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     flag_n,
    output logic                     flag_v,
    output logic                     flag_z,
    output logic                     out_err
);

    localparam int SW = $clog2(WIDTH);
    localparam int HW = WIDTH / 2;
    localparam int NL = WIDTH / LANE_W;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_v_q, flag_v_d;
    logic             flag_z_q, flag_z_d;

    logic             accept, mul_start, mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0] sum, diff, sat, padd, ror;
    logic [SW:0]      lsh;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err, alu_v, upd_nv, upd_z;

    assign in_ready  = rst_n && (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && op == OP_MUL;
    assign out_valid = state_q == DONE;
    assign result    = result_q;
    assign out_err   = err_q;
    assign flag_n    = flag_n_q;
    assign flag_v    = flag_v_q;
    assign flag_z    = flag_z_q;

    // signed overflow always saturates toward the sign of a
    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign sat     = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    // shamt=0 makes the left part shift by WIDTH, which yields zero and passes a
    assign lsh = (SW+1)'(WIDTH) - {1'b0, shamt};
    assign ror = (a >> shamt) | (a << lsh);

    for (genvar i = 0; i < NL; i++) begin : g_lane
        logic [LANE_W-1:0] lane_a, lane_b, lane_s;
        logic              lane_ovf;
        assign lane_a   = a[i*LANE_W +: LANE_W];
        assign lane_b   = b[i*LANE_W +: LANE_W];
        assign lane_s   = lane_a + lane_b;
        assign lane_ovf = (lane_a[LANE_W-1] == lane_b[LANE_W-1]) && (lane_s[LANE_W-1] != lane_a[LANE_W-1]);
        assign padd[i*LANE_W +: LANE_W] = lane_ovf ? {lane_a[LANE_W-1], {(LANE_W-1){!lane_a[LANE_W-1]}}} : lane_s;
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // single-cycle result and which flags it is allowed to touch
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        alu_v   = 1'b0;
        upd_nv  = 1'b0;
        upd_z   = 1'b1;
        case (op)
            OP_ADD: begin
                alu_res = add_ovf ? sat : sum;
                alu_v   = add_ovf;
                upd_nv  = 1'b1;
            end
            OP_SUB: begin
                alu_res = sub_ovf ? sat : diff;
                alu_v   = sub_ovf;
                upd_nv  = 1'b1;
            end
            OP_XOR:    alu_res = a ^ b;
            OP_SLL:    alu_res = a << shamt;
            OP_SRA:    alu_res = $signed(a) >>> shamt;
            OP_ROR:    alu_res = ror;
            OP_PADDSB: begin
                alu_res = padd;
                upd_z   = 1'b0;
            end
            OP_LLB: begin
                alu_res = {b[WIDTH-1:HW], imm};
                upd_z   = 1'b0;
            end
            OP_LHB: begin
                alu_res = {imm, b[HW-1:0]};
                upd_z   = 1'b0;
            end
            OP_MUL:    alu_res = '0;
            default: begin
                alu_err = 1'b1;
                upd_z   = 1'b0;
            end
        endcase
    end

    // control: load results on accept or multiplier completion, drain on out_ready
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        err_d    = err_q;
        flag_n_d = flag_n_q;
        flag_v_d = flag_v_q;
        flag_z_d = flag_z_q;
        if (mul_start) begin
            state_d = MUL_BUSY;
        end else if (accept) begin
            state_d  = DONE;
            result_d = alu_res;
            err_d    = alu_err;
            flag_n_d = upd_nv ? alu_res[WIDTH-1] : flag_n_q;
            flag_v_d = upd_nv ? alu_v : flag_v_q;
            flag_z_d = upd_z ? (alu_res == '0) : flag_z_q;
        end else if (state_q == MUL_BUSY && mul_done) begin
            state_d  = DONE;
            result_d = mul_prod;
            err_d    = 1'b0;
            flag_z_d = mul_prod == '0;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            err_q    <= 1'b0;
            flag_n_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            err_q    <= err_d;
            flag_n_q <= flag_n_d;
            flag_v_q <= flag_v_d;
            flag_z_q <= flag_z_d;
        end
    end

endmodule

// File: tb/tb_pipe_alu.sv
// tb_pipe_alu: directed and randomized checks of pipe_alu against an arithmetic reference model
module tb_pipe_alu;
    import pipe_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [3:0]  shamt = '0;
    logic [7:0]  imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        flag_n, flag_v, flag_z, out_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_res;
    logic        m_err;
    logic        m_n = 1'b0;
    logic        m_v = 1'b0;
    logic        m_z = 1'b0;

    pipe_alu #(.WIDTH(16), .LANE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // reference: signed values as plain integers, clamped to the representable range
    task automatic ref_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                          input logic [3:0] s, input logic [7:0] im);
        int sx, sy, t;
        longint p;
        sx = int'($signed(x));
        sy = int'($signed(y));
        m_err = 1'b0;
        m_res = '0;
        case (o)
            OP_ADD, OP_SUB: begin
                t = (o == OP_ADD) ? sx + sy : sx - sy;
                m_v = (t > 32767) || (t < -32768);
                if (t > 32767) t = 32767;
                if (t < -32768) t = -32768;
                m_res = t[15:0];
                m_n = t < 0;
                m_z = t == 0;
            end
            OP_XOR: begin m_res = x ^ y; m_z = m_res == 0; end
            OP_SLL: begin m_res = x << s; m_z = m_res == 0; end
            OP_SRA: begin t = sx >>> s; m_res = t[15:0]; m_z = m_res == 0; end
            OP_ROR: begin
                m_res = x;
                repeat (int'(s)) m_res = {m_res[0], m_res[15:1]};
                m_z = m_res == 0;
            end
            OP_PADDSB: begin
                for (int i = 0; i < 4; i++) begin
                    int la, lb, ls;
                    la = int'((x >> (4 * i)) & 16'hF);
                    lb = int'((y >> (4 * i)) & 16'hF);
                    if (la > 7) la -= 16;
                    if (lb > 7) lb -= 16;
                    ls = la + lb;
                    if (ls > 7) ls = 7;
                    if (ls < -8) ls = -8;
                    m_res[4*i +: 4] = ls[3:0];
                end
            end
            OP_LLB: m_res = (y & 16'hFF00) | {8'h00, im};
            OP_LHB: m_res = (y & 16'h00FF) | {im, 8'h00};
            OP_MUL: begin
                p = longint'(x) * longint'(y);
                m_res = p[15:0];
                m_z = m_res == 0;
            end
            default: m_err = 1'b1;
        endcase
    endtask

    task automatic set_req(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                           input logic [3:0] s, input logic [7:0] im);
        op = o; a = x; b = y; shamt = s; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++;
        if ({out_valid, out_err, result} !== 18'h0) begin
            errors++; $display("FAIL reset_outputs got v=%b e=%b r=%h want 0", out_valid, out_err, result);
        end
        checks++;
        if ({flag_n, flag_v, flag_z} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {flag_n, flag_v, flag_z});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_sat();
        ref_op(OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 8'h00);
        set_req(OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 8'h00);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency out_valid got %b want 1", out_valid); end
        checks++;
        if (result !== 16'h7FFF) begin errors++; $display("FAIL add_sat result got %h want 7fff", result); end
        checks++;
        if ({flag_n, flag_v, flag_z} !== 3'b010) begin
            errors++; $display("FAIL add_sat_flags nvz got %b want 010", {flag_n, flag_v, flag_z});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        ref_op(OP_SUB, 16'h0005, 16'h0005, 4'd0, 8'h00);
        set_req(OP_SUB, 16'h0005, 16'h0005, 4'd0, 8'h00);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h0000 || flag_z !== 1'b1) begin
            errors++; $display("FAIL b2b_sub got v=%b r=%h z=%b want 1 0000 1", out_valid, result, flag_z);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
        ref_op(OP_XOR, 16'hFFFF, 16'h0001, 4'd0, 8'h00);
        set_req(OP_XOR, 16'hFFFF, 16'h0001, 4'd0, 8'h00);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'hFFFE) begin
            errors++; $display("FAIL b2b_xor got v=%b r=%h want 1 fffe", out_valid, result);
        end
        checks++;
        if ({flag_n, flag_v, flag_z} !== 3'b000) begin
            errors++; $display("FAIL b2b_xor_flags nvz got %b want 000", {flag_n, flag_v, flag_z});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_mul();
        int cyc;
        logic busy_ok;
        ref_op(OP_MUL, 16'h0003, 16'hFFFE, 4'd0, 8'h00);
        set_req(OP_MUL, 16'h0003, 16'hFFFE, 4'd0, 8'h00);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!out_valid && cyc < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != 17) begin errors++; $display("FAIL mul_latency got %0d want 17", cyc); end
        checks++;
        if (result !== 16'hFFFA) begin errors++; $display("FAIL mul_result got %h want fffa", result); end
        checks++;
        if (!busy_ok || in_ready !== 1'b0) begin errors++; $display("FAIL mul_in_ready_busy got high want 0"); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_paddsb_ror();
        out_ready = 1'b1;
        ref_op(OP_PADDSB, 16'h7777, 16'h1111, 4'd0, 8'h00);
        set_req(OP_PADDSB, 16'h7777, 16'h1111, 4'd0, 8'h00);
        @(posedge clk);
        #1;
        checks++;
        if (result !== 16'h7777) begin errors++; $display("FAIL paddsb got %h want 7777", result); end
        ref_op(OP_ROR, 16'h8001, 16'h0000, 4'd1, 8'h00);
        set_req(OP_ROR, 16'h8001, 16'h0000, 4'd1, 8'h00);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (result !== 16'hC000) begin errors++; $display("FAIL ror got %h want c000", result); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        ref_op(OP_LLB, 16'h0000, 16'hABCD, 4'd0, 8'h12);
        set_req(OP_LLB, 16'h0000, 16'hABCD, 4'd0, 8'h12);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 16'hAB12 || in_ready !== 1'b0 ||
                {flag_n, flag_v, flag_z} !== {m_n, m_v, m_z}) begin
                errors++;
                $display("FAIL hold_c%0d got v=%b r=%h rdy=%b nvz=%b want 1 ab12 0 %b", i, out_valid,
                         result, in_ready, {flag_n, flag_v, flag_z}, {m_n, m_v, m_z});
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_mul_reset();
        int stale;
        set_req(OP_MUL, 16'h1234, 16'h5678, 4'd0, 8'h00);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_n = 1'b0; m_v = 1'b0; m_z = 1'b0;
        checks++;
        if ({out_valid, out_err, result, flag_n, flag_v, flag_z, in_ready} !== 22'h0) begin
            errors++; $display("FAIL mul_abort got v=%b e=%b r=%h nvz=%b rdy=%b want all 0", out_valid,
                               out_err, result, {flag_n, flag_v, flag_z}, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mul_abort_release got rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
        stale = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL mul_abort_stale got %0d valid cycles want 0", stale); end
    endtask

    task automatic test_random();
        int cyc, exp_lat, hold;
        logic [3:0] o;
        logic [15:0] x, y;
        logic [3:0] s;
        logic [7:0] im;
        for (int n = 0; n < 150; n++) begin
            o = 4'($urandom_range(0, 15));
            x = 16'($urandom);
            y = 16'($urandom);
            s = 4'($urandom);
            im = 8'($urandom);
            if (n % 5 == 0) x = {x[15], {15{~x[15]}}};
            ref_op(o, x, y, s, im);
            exp_lat = (o == OP_MUL) ? 17 : 1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_in_ready got %b want 1", n, in_ready); end
            set_req(o, x, y, s, im);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            cyc = 1;
            while (!out_valid && cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            checks++;
            if (cyc != exp_lat) begin errors++; $display("FAIL rnd%0d_latency op=%0d got %0d want %0d", n, o, cyc, exp_lat); end
            hold = $urandom_range(0, 2);
            for (int h = 0; h <= hold; h++) begin
                checks++;
                if (result !== m_res || out_err !== m_err || {flag_n, flag_v, flag_z} !== {m_n, m_v, m_z}) begin
                    errors++;
                    $display("FAIL rnd%0d_h%0d op=%0d a=%h b=%h sh=%0d imm=%h got r=%h e=%b nvz=%b want r=%h e=%b nvz=%b",
                             n, h, o, x, y, s, im, result, out_err, {flag_n, flag_v, flag_z}, m_res, m_err,
                             {m_n, m_v, m_z});
                end
                if (h < hold) begin
                    @(posedge clk);
                    #1;
                end
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_add_sat();
        test_back_to_back();
        test_mul();
        test_paddsb_ror();
        test_hold();
        test_mul_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter WIDTH, default 16: datapath width; SHALL be a multiple of LANE_W and at least 8.
REQ-002 Parameter LANE_W, default 4: lane width for PADDSB.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block accepts the request this cycle.
REQ-007 op  input  4  opcode; encoding defined in the package.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 shamt  input  clog2(WIDTH)  shift/rotate amount.
REQ-010 imm  input  WIDTH/2  immediate for LLB/LHB.
REQ-011 out_valid  output  1  result register holds a valid result.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 result  output  WIDTH  registered result.
REQ-014 flag_n, flag_v, flag_z  output  1 each  registered condition flags.
REQ-015 out_err  output  1  result came from an illegal opcode; valid with out_valid.

Function
REQ-016 A request SHALL be accepted on a cycle with in_valid && in_ready; operands and op SHALL be captured at acceptance.
REQ-017 States: IDLE, MUL_BUSY, DONE.
REQ-018 in_ready SHALL be 1 in IDLE, 0 in MUL_BUSY, and equal out_ready in DONE.
REQ-019 Single-cycle ops SHALL assert out_valid on the cycle after acceptance and move to DONE.
REQ-020 MUL SHALL iterate one bit per cycle (shift-add) and assert out_valid exactly WIDTH+1 cycles after acceptance.
REQ-021 In DONE, result, out_err and out_valid SHALL hold while out_ready=0.
REQ-022 On out_ready=1 in DONE: a simultaneous new acceptance SHALL load the next result (back-to-back, throughput 1 for single-cycle ops); otherwise the block SHALL return to IDLE with out_valid=0.
REQ-023 ADD/SUB: a+b, a-b in two's complement; on signed overflow result SHALL saturate to 0x7F..F (positive) or 0x80..0 (negative).
REQ-024 XOR: a^b. SLL: logical left by shamt. SRA: arithmetic right by shamt. ROR: rotate right by shamt; shamt=0 passes a.
REQ-025 PADDSB: independent per-lane signed LANE_W-bit add of a and b, each lane saturating; no carry between lanes.
REQ-026 LLB: (b & upper-half mask) | zero-extended imm. LHB: (b & lower-half mask) | (imm << WIDTH/2).
REQ-027 MUL: low WIDTH bits of a*b; sign-agnostic.
REQ-028 Illegal opcode: result 0, out_err 1, flags unchanged; all legal ops give out_err 0.
REQ-029 Flags SHALL update in the same edge that loads result. ADD/SUB: N=result MSB, V=overflow occurred, Z=(result==0). XOR, SLL, SRA, ROR, MUL: Z only. PADDSB, LLB, LHB: none.
REQ-030 A request while not in_ready SHALL be ignored; the source holds it until accepted.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, result=0, out_valid=0, out_err=0, flag_n=0, flag_v=0, flag_z=0, and clear the multiplier state, including mid-MUL; no result is produced for an aborted operation.
REQ-032 in_ready SHALL be 0 while rst_n is low and 1 on the first cycle after release.

Structure
REQ-033 A shared package SHALL hold the opcode constants (ADD=0, SUB=1, XOR=3, SLL=4, SRA=5, ROR=6, PADDSB=7, LHB=10, LLB=11, MUL=12) and the state enum.
REQ-034 The iterative multiplier SHALL be one sub-module, alu_mul_iter, with start/done handshake; the rest is combinational inside pipe_alu.

Verification (WIDTH=16, LANE_W=4)
REQ-035 ADD a=0x7FFF, b=0x0001 -> result 0x7FFF, V=1, N=0, Z=0, out_valid one cycle after accept.
REQ-036 SUB a=0x0005, b=0x0005, then XOR a=0xFFFF, b=0x0001 back-to-back with out_ready=1 -> 0x0000 (Z=1), then 0xFFFE (Z=0, N and V unchanged at 0); one result per cycle.
REQ-037 MUL a=0x0003, b=0xFFFE -> 0xFFFA exactly 17 cycles after accept; in_ready=0 throughout.
REQ-038 PADDSB a=0x7777, b=0x1111 -> 0x7777; ROR a=0x8001, shamt=1 -> 0xC000.
REQ-039 Hold out_ready=0 for 5 cycles after an LLB with b=0xABCD, imm=0x12 -> result stays 0xAB12, in_ready=0, flags unchanged.
REQ-040 Assert rst_n=0 at cycle 8 of a MUL -> outputs zero immediately; after release in_ready=1 and no stale out_valid.
